// File: rtl/display_scan_mux.sv
// display_scan_mux: time-multiplexed scanner for common-anode seven-segment banks.
// Each digit slot is a BLANK interval (all anodes off) followed by a DRIVE interval
// (one active-low anode, gated by that digit's enable). Digit value, enable and
// optional duty are captured only at slot entry, so the whole slot is glitch-free.
// Optional feature macro: SCAN_PWM_EN adds a per-slot duty input that limits how
// many DRIVE cycles the anode is actually asserted.
module display_scan_mux #(
    parameter  int NUM_DIGITS   = 2,
    parameter  int DATA_W       = 4,
    parameter  int DWELL_CYCLES = 24000,
    parameter  int BLANK_CYCLES = 16,
    localparam int IDX_W        = $clog2(NUM_DIGITS),
    localparam int DUTY_W       = $clog2(DWELL_CYCLES + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_DIGITS*DATA_W-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]        digit_en,
`ifdef SCAN_PWM_EN
    input  logic [DUTY_W-1:0]            duty,
`endif
    output logic [DATA_W-1:0]            s,
    output logic [NUM_DIGITS-1:0]        anode_n,
    output logic [IDX_W-1:0]             digit_idx,
    output logic                         frame_start
);

    localparam int MAX_CNT = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int CMP_W   = (CNT_W > DUTY_W) ? CNT_W : DUTY_W;

    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_ZERO   = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t                  state_r, state_s;
    logic [CNT_W-1:0]        cnt_r, cnt_s;
    logic [IDX_W-1:0]        idx_r, idx_s;
    logic [DATA_W-1:0]       s_r, s_s;
    logic                    en_r, en_s;
    logic [NUM_DIGITS-1:0]   anode_r, anode_s;
    logic                    frame_r, frame_s;
    logic                    enter_s;
    logic                    lit_s;
    logic [DATA_W-1:0]       sel_data_s;
    logic                    sel_en_s;
`ifdef SCAN_PWM_EN
    logic [DUTY_W-1:0]       duty_r, duty_s;
`endif

    // Slot sequencing: BLANK/DRIVE state, cycle counter and digit index advance.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r + CNT_ONE;
        idx_s   = idx_r;
        enter_s = 1'b0;
        case (state_r)
            ST_BLANK: begin
                // A zero-length blank only occurs right after reset.
                if ((BLANK_CYCLES == 0) || (cnt_r == BLANK_LAST)) begin
                    state_s = ST_DRIVE;
                    cnt_s   = CNT_ZERO;
                    enter_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_DRIVE: begin
                if (cnt_r == DWELL_LAST) begin
                    cnt_s = CNT_ZERO;
                    idx_s = (idx_r == IDX_LAST) ? IDX_ZERO : (idx_r + IDX_ONE);
                    if (BLANK_CYCLES == 0) begin
                        state_s = ST_DRIVE;
                        enter_s = 1'b1;
                    end else begin
                        state_s = ST_BLANK;
                    end
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = ST_BLANK;
                cnt_s   = CNT_ZERO;
                idx_s   = IDX_ZERO;
            end
        endcase
    end

    // Select the value and enable of the digit whose slot starts next (one-hot mux).
    always_comb begin
        sel_data_s = {DATA_W{1'b0}};
        sel_en_s   = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            sel_data_s = sel_data_s | (digit_data[i*DATA_W +: DATA_W] & {DATA_W{idx_s == IDX_W'(i)}});
            sel_en_s   = sel_en_s | (digit_en[i] & (idx_s == IDX_W'(i)));
        end
    end

    // Next values of the registered outputs; anode follows the state the next cycle is in.
    always_comb begin
        s_s     = enter_s ? sel_data_s : s_r;
        en_s    = enter_s ? sel_en_s : en_r;
`ifdef SCAN_PWM_EN
        duty_s  = enter_s ? duty : duty_r;
        lit_s   = (state_s == ST_DRIVE) && en_s && (CMP_W'(cnt_s) < CMP_W'(duty_s));
`else
        lit_s   = (state_s == ST_DRIVE) && en_s;
`endif
        anode_s = {NUM_DIGITS{1'b1}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            anode_s[i] = ~(lit_s && (idx_s == IDX_W'(i)));
        end
        frame_s = enter_s && (idx_s == IDX_ZERO);
    end

    // State and output registers; reset blanks the display immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_BLANK;
            cnt_r   <= CNT_ZERO;
            idx_r   <= IDX_ZERO;
            s_r     <= {DATA_W{1'b0}};
            en_r    <= 1'b0;
            anode_r <= {NUM_DIGITS{1'b1}};
            frame_r <= 1'b0;
`ifdef SCAN_PWM_EN
            duty_r  <= {DUTY_W{1'b0}};
`endif
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            s_r     <= s_s;
            en_r    <= en_s;
            anode_r <= anode_s;
            frame_r <= frame_s;
`ifdef SCAN_PWM_EN
            duty_r  <= duty_s;
`endif
        end
    end

    assign s           = s_r;
    assign anode_n     = anode_r;
    assign digit_idx   = idx_r;
    assign frame_start = frame_r;

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux: a 2-digit instance (DWELL=8, BLANK=2) and a
// 4-digit/8-bit instance (DWELL=3, BLANK=0). Cycle 0 is the cycle in which reset
// is released; cycle k follows the k-th rising edge after release.
module tb_display_scan_mux;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  digit_data_a;
    logic [1:0]  digit_en_a;
    logic [3:0]  s_a;
    logic [1:0]  anode_n_a;
    logic [0:0]  digit_idx_a;
    logic        frame_start_a;
    logic [31:0] digit_data_b;
    logic [3:0]  digit_en_b;
    logic [7:0]  s_b;
    logic [3:0]  anode_n_b;
    logic [1:0]  digit_idx_b;
    logic        frame_start_b;
`ifdef SCAN_PWM_EN
    logic [3:0]  duty_a;
    logic [1:0]  duty_b;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    display_scan_mux #(.NUM_DIGITS(2), .DATA_W(4), .DWELL_CYCLES(8), .BLANK_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset), .digit_data(digit_data_a), .digit_en(digit_en_a),
`ifdef SCAN_PWM_EN
        .duty(duty_a),
`endif
        .s(s_a), .anode_n(anode_n_a), .digit_idx(digit_idx_a), .frame_start(frame_start_a));

    display_scan_mux #(.NUM_DIGITS(4), .DATA_W(8), .DWELL_CYCLES(3), .BLANK_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .digit_data(digit_data_b), .digit_en(digit_en_b),
`ifdef SCAN_PWM_EN
        .duty(duty_b),
`endif
        .s(s_b), .anode_n(anode_n_b), .digit_idx(digit_idx_b), .frame_start(frame_start_b));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Assert reset, then release it 1 ns after a rising edge; that cycle is cycle 0.
    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        cyc = 0;
    endtask

    // Expected 2-digit anode pattern for a 20-cycle frame (2 blank + 8 drive per digit).
    function automatic logic [1:0] exp_anode_a(input int c, input logic [1:0] en, input int on_len);
        int m;
        m = c % 20;
        if (m >= 2 && m < 2 + on_len && en[0]) return 2'b10;
        if (m >= 12 && m < 12 + on_len && en[1]) return 2'b01;
        return 2'b11;
    endfunction

    // Expected s: digit 0 from cycle 2 to 11, digit 1 afterwards, zero before the first slot.
    function automatic logic [3:0] exp_s_a(input int c, input logic [3:0] d0, input logic [3:0] d1);
        int m;
        m = c % 20;
        if (m < 2) return (c < 20) ? 4'h0 : d1;
        if (m < 12) return d0;
        return d1;
    endfunction

    // Run dut_a from the current cycle through last_cyc comparing against the 2-digit frame model.
    task automatic run_a(input int last_cyc, input logic [1:0] en, input logic [3:0] d0,
                         input logic [3:0] d1, input int on_len);
        while (cyc <= last_cyc) begin
            check("a_anode", 32'(anode_n_a), 32'(exp_anode_a(cyc, en, on_len)));
            check("a_s", 32'(s_a), 32'(exp_s_a(cyc, d0, d1)));
            check("a_idx", 32'(digit_idx_a), ((cyc % 20) >= 10) ? 32'd1 : 32'd0);
            check("a_frame", 32'(frame_start_a), ((cyc % 20) == 2) ? 32'd1 : 32'd0);
            step();
        end
    endtask

    initial begin
        digit_data_a = 8'h08;
        digit_en_a   = 2'b11;
        digit_data_b = 32'hD4C3B2A1;
        digit_en_b   = 4'hF;
`ifdef SCAN_PWM_EN
        duty_a = 4'd8;
        duty_b = 2'd3;
`endif

        // Basic scan with both digits enabled.
        do_reset();
        check("rst_anode", 32'(anode_n_a), 32'h3);
        check("rst_s", 32'(s_a), 32'h0);
        run_a(41, 2'b11, 4'h8, 4'h0, 8);

        // Mid-slot data change stays invisible until digit 0's next slot.
        do_reset();
        while (cyc < 5) step();
        digit_data_a = 8'h05;
        while (cyc <= 9) begin
            check("mid_s_hold", 32'(s_a), 32'h8);
            step();
        end
        while (cyc < 22) step();
        check("mid_s_new", 32'(s_a), 32'h5);
        digit_data_a = 8'h08;

        // Digit 0 disabled: its slot stays dark, period unchanged, s still updates.
        digit_en_a = 2'b10;
        do_reset();
        run_a(41, 2'b10, 4'h8, 4'h0, 8);
        digit_en_a = 2'b11;

        // Asynchronous reset between clock edges in the middle of a drive slot.
        do_reset();
        while (cyc < 6) step();
        check("pre_async_anode", 32'(anode_n_a), 32'h2);
        #2;
        reset = 1'b0;
        #1;
        check("async_anode", 32'(anode_n_a), 32'h3);
        check("async_s", 32'(s_a), 32'h0);
        check("async_idx", 32'(digit_idx_a), 32'h0);
        check("async_frame", 32'(frame_start_a), 32'h0);
        do_reset();
        run_a(21, 2'b11, 4'h8, 4'h0, 8);

        // 4 digits, 8-bit values, no blanking, 3-cycle dwell.
        do_reset();
        while (cyc <= 25) begin
            if (cyc == 0) begin
                check("b_anode", 32'(anode_n_b), 32'hF);
                check("b_s", 32'(s_b), 32'h0);
                check("b_idx", 32'(digit_idx_b), 32'h0);
                check("b_frame", 32'(frame_start_b), 32'h0);
            end else begin
                int k;
                logic [3:0] one_low;
                k = ((cyc - 1) / 3) % 4;
                one_low = ~(4'b0001 << k);
                check("b_anode", 32'(anode_n_b), 32'(one_low));
                check("b_s", 32'(s_b), 32'(digit_data_b[k*8 +: 8]));
                check("b_idx", 32'(digit_idx_b), 32'(k));
                check("b_frame", 32'(frame_start_b), (((cyc - 1) % 12) == 0) ? 32'd1 : 32'd0);
            end
            step();
        end

`ifdef SCAN_PWM_EN
        // Duty limits anode-on time; s and frame timing unchanged.
        duty_a = 4'd3;
        do_reset();
        run_a(21, 2'b11, 4'h8, 4'h0, 3);
        duty_a = 4'd0;
        do_reset();
        run_a(21, 2'b11, 4'h8, 4'h0, 0);
        duty_a = 4'd8;
        do_reset();
        run_a(21, 2'b11, 4'h8, 4'h0, 8);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scan_mux.md
Name: display_scan_mux

Overview:
- Parametrised time-multiplexed display scanner for common-anode seven-segment banks. Successor to the fixed 2:1 digit select.
- Round-robins over NUM_DIGITS packed digit values and presents one value on s, for the downstream seven-segment decoder.
- Drives one active-low anode enable at a time, with a blanking interval between digits to prevent ghosting.
- Sits between the keypad/data registers and the seven-segment decoder plus anode pins.

Parameters:
- NUM_DIGITS, 2, number of multiplexed digits (>=2).
- DATA_W, 4, width of each digit value.
- DWELL_CYCLES, 24000, clk cycles each digit slot is driven (>=1).
- BLANK_CYCLES, 16, clk cycles with all anodes off before each slot (>=0).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- digit_data  in  NUM_DIGITS*DATA_W  packed values; digit i at [i*DATA_W +: DATA_W].
- digit_en  in  NUM_DIGITS  per-digit enable; a disabled digit keeps its slot with its anode off.
- s  out  DATA_W  selected digit value, registered.
- anode_n  out  NUM_DIGITS  active-low anode enables, registered; at most one bit low.
- digit_idx  out  $clog2(NUM_DIGITS)  index of the current/most recent slot.
- frame_start  out  1  one-cycle pulse on the first DRIVE cycle of digit 0.

Behaviour:
- Reset (async assert, any time, including mid-slot):
  - state=BLANK, cnt=0, digit_idx=0, s=0, anode_n=all ones, frame_start=0.
  - Takes effect immediately, without waiting for a clock edge.
- State BLANK:
  - All anodes off; s holds its last value; cnt counts 0..BLANK_CYCLES-1.
  - At cnt==BLANK_CYCLES-1: go to DRIVE, cnt<=0.
  - On that same edge, sample digit_data[digit_idx] into s and digit_en[digit_idx] into an internal enable latch.
  - If BLANK_CYCLES==0, BLANK is never entered: DRIVE-to-DRIVE transitions sample directly, and after reset the first edge enters DRIVE.
- State DRIVE:
  - anode_n[digit_idx] = ~latched enable; all other anode bits are 1; cnt counts 0..DWELL_CYCLES-1.
  - At cnt==DWELL_CYCLES-1: digit_idx <= (digit_idx==NUM_DIGITS-1) ? 0 : digit_idx+1, cnt<=0, go to BLANK.
- Input sampling: inputs are sampled only at slot entry. Changes to digit_data or digit_en during a slot are invisible until that digit's next slot.
- Frame period is fixed: NUM_DIGITS*(BLANK_CYCLES+DWELL_CYCLES) cycles, independent of digit_en.
- frame_start is high exactly on the first DRIVE cycle with digit_idx==0.
- Timing after reset release (BLANK=16, DWELL=100):
  - anode_n[0] low for cycles 16..115.
  - anode_n[1] low for cycles 132..231.
  - Period 232.
- Counter width: $clog2(max(DWELL_CYCLES,BLANK_CYCLES)+1). No overflow is possible.
- All digits disabled: scanning continues, anode_n stays all ones, s still updates.

Optional Feature:
- Macro: SCAN_PWM_EN.
- When defined:
  - Adds input port duty, width $clog2(DWELL_CYCLES+1), sampled at slot entry.
  - The anode is asserted only while cnt < duty within DRIVE.
  - duty=0 keeps the digit dark; duty>=DWELL_CYCLES gives full on.
  - s, digit_idx and frame timing are unchanged.
- When undefined: no duty port; the anode is on for the full DRIVE interval.

Test Plan (NUM_DIGITS=2, DATA_W=4, DWELL=8, BLANK=2, unless noted):
1. Basic scan. digit_data={4'b0000,4'b1000}, digit_en=2'b11, release reset.
   - anode_n=11 on cycles 0-1; s=1000 and anode_n=10 on cycles 2-9.
   - anode_n=11 on cycles 10-11; s=0000 and anode_n=01 on cycles 12-19.
   - frame_start pulses at cycles 2 and 22.
2. Mid-slot data change. Change digit0 to 4'b0101 at cycle 5.
   - s stays 1000 through cycle 9; s=0101 at cycle 22.
3. Disabled digit. digit_en=2'b10.
   - anode_n[0] never low; anode_n=01 on cycles 12-19; period still 20 cycles.
4. Async reset mid-slot. Assert reset at cycle 6, between clock edges.
   - Immediately: anode_n=11, s=0, digit_idx=0.
   - After release, the sequence restarts exactly as in test 1.
5. Parameter sweep. NUM_DIGITS=4, DATA_W=8, BLANK=0, DWELL=3.
   - digit_idx runs 0,1,2,3,0 every 3 cycles; never more than one anode low.
   - s matches each byte of digit_data.
6. (SCAN_PWM_EN) duty=3.
   - anode_n[0] low only on cycles 2-4, with s=1000 held through cycle 9.
   - duty=0 keeps the digit dark; duty=8 gives full dwell.
